// File: rtl/sap1_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sap1_pkg
//  Description : Shared opcodes, ring-counter states, control-word bit
//                positions, control-word constants and the built-in program
//                image for the SAP-1 computer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap1_pkg;

    // Opcodes carried in IR[7:4]; any other value executes as a NOP.
    localparam logic [3:0] c_OP_LDA = 4'h0;
    localparam logic [3:0] c_OP_ADD = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    // Six-phase ring counter, one phase per clock.
    typedef enum logic [2:0] {
        T1 = 3'd0,
        T2 = 3'd1,
        T3 = 3'd2,
        T4 = 3'd3,
        T5 = 3'd4,
        T6 = 3'd5
    } ring_t;

    // Bit positions inside the 12-bit control word
    // {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}. Names starting with N are
    // active-low strobes.
    localparam int c_CP  = 11;
    localparam int c_EP  = 10;
    localparam int c_NLM = 9;
    localparam int c_NCE = 8;
    localparam int c_NLI = 7;
    localparam int c_NEI = 6;
    localparam int c_NLA = 5;
    localparam int c_EA  = 4;
    localparam int c_SU  = 3;
    localparam int c_EU  = 2;
    localparam int c_NLB = 1;
    localparam int c_NLO = 0;

    // Control words for each phase.
    localparam logic [11:0] c_CW_IDLE     = 12'h3E3; // nothing driven or loaded
    localparam logic [11:0] c_CW_FETCH_PC = 12'h5E3; // T1: PC -> MAR
    localparam logic [11:0] c_CW_INC_PC   = 12'hBE3; // T2: PC + 1
    localparam logic [11:0] c_CW_LOAD_IR  = 12'h263; // T3: mem -> IR
    localparam logic [11:0] c_CW_OPND_MAR = 12'h1A3; // T4: IR[3:0] -> MAR
    localparam logic [11:0] c_CW_LDA_T5   = 12'h2C3; // mem -> A
    localparam logic [11:0] c_CW_MEM_B    = 12'h2E1; // mem -> B
    localparam logic [11:0] c_CW_ADD_T6   = 12'h3C7; // A + B -> A
    localparam logic [11:0] c_CW_SUB_T6   = 12'h3CF; // A - B -> A
    localparam logic [11:0] c_CW_OUT_T4   = 12'h3F2; // A -> OUT

    // Built-in program, byte i at bits [8*i +: 8]:
    //   0: LDA 9   1: ADD A   2: SUB B   3: OUT   4: HLT
    //   9: 0x10    A: 0x14    B: 0x18    others: 0x00
    localparam logic [127:0] c_BUILTIN_PROGRAM = {
        8'h00, 8'h00, 8'h00, 8'h00,          // F..C
        8'h18, 8'h14, 8'h10,                 // B..9
        8'h00, 8'h00, 8'h00, 8'h00,          // 8..5
        8'hF0, 8'hE0, 8'h2B, 8'h1A, 8'h09    // 4..0
    };

endpackage
`default_nettype wire

// File: rtl/sap1_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sap1_controller
//  Description : Six-phase ring counter, HLT latch and control-word decoder
//                for the SAP-1 computer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap1_controller
    import sap1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_opcode,
    output logic [11:0] o_contword,
    output logic        o_hlt
);

    ring_t       r_state;
    ring_t       w_state_next;
    logic        r_hlt;
    logic        w_hlt_set;
    logic [11:0] w_contword;

    // HLT is latched at the edge that ends T4 of a HLT instruction.
    assign w_hlt_set = (r_state == T4) && (i_opcode == c_OP_HLT);

    // Ring counter and halt latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= T1;
            r_hlt   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hlt   <= r_hlt | w_hlt_set;
        end
    end

    // Next phase and control-word decode from (phase, opcode).
    always_comb begin
        w_state_next = r_state;
        w_contword   = c_CW_IDLE;

        case (r_state)
            T1:      w_state_next = T2;
            T2:      w_state_next = T3;
            T3:      w_state_next = T4;
            T4:      w_state_next = T5;
            T5:      w_state_next = T6;
            T6:      w_state_next = T1;
            default: w_state_next = T1;
        endcase

        case (r_state)
            T1: w_contword = c_CW_FETCH_PC;
            T2: w_contword = c_CW_INC_PC;
            T3: w_contword = c_CW_LOAD_IR;
            T4: begin
                case (i_opcode)
                    c_OP_LDA, c_OP_ADD, c_OP_SUB: w_contword = c_CW_OPND_MAR;
                    c_OP_OUT:                     w_contword = c_CW_OUT_T4;
                    default:                      w_contword = c_CW_IDLE;
                endcase
            end
            T5: begin
                case (i_opcode)
                    c_OP_LDA:           w_contword = c_CW_LDA_T5;
                    c_OP_ADD, c_OP_SUB: w_contword = c_CW_MEM_B;
                    default:            w_contword = c_CW_IDLE;
                endcase
            end
            T6: begin
                case (i_opcode)
                    c_OP_ADD: w_contword = c_CW_ADD_T6;
                    c_OP_SUB: w_contword = c_CW_SUB_T6;
                    default:  w_contword = c_CW_IDLE;
                endcase
            end
            default: w_contword = c_CW_IDLE;
        endcase

        // Once halted the machine parks in T5 with every strobe inactive, so
        // no register in the datapath can change until the next clear.
        if (r_hlt) begin
            w_state_next = r_state;
            w_contword   = c_CW_IDLE;
        end
    end

    assign o_contword = w_contword;
    assign o_hlt      = r_hlt;

endmodule
`default_nettype wire

// File: rtl/sap1_computer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sap1_computer
//  Description : SAP-1 8-bit computer: PC, MAR, 16x8 ROM, IR, A, B,
//                adder/subtractor and output register on one shared bus,
//                sequenced by sap1_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap1_computer
    import sap1_pkg::*;
#(
    // 16x8 program image, byte i at bits [8*i +: 8]. The memory is never
    // written, so it is realised as a constant table.
    parameter logic [127:0] MEM_IMAGE = c_BUILTIN_PROGRAM
)(
    input  logic        Clk,
    input  logic        Clr,
    output logic        HLT,
    output logic [7:0]  LEDOUT,
    output logic [11:0] CONTWORD
);

    logic [3:0]  r_pc;
    logic [3:0]  r_mar;
    logic [7:0]  r_ir;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_out;

    logic [11:0] w_cw;
    logic        w_hlt;
    logic [7:0]  w_mem;
    logic [7:0]  w_alu;
    logic [7:0]  w_bus;

    sap1_controller u_ctrl (
        .clk        (Clk),
        .rst        (Clr),
        .i_opcode   (r_ir[7:4]),
        .o_contword (w_cw),
        .o_hlt      (w_hlt)
    );

    // Combinational memory read at the address held in MAR.
    assign w_mem = MEM_IMAGE[{r_mar, 3'b000} +: 8];

    // 8-bit modulo-256 adder/subtractor, no flags.
    assign w_alu = w_cw[c_SU] ? (r_a - r_b) : (r_a + r_b);

    // Bus source select; the controller never enables two sources at once.
    always_comb begin
        w_bus = 8'h00;
        if (w_cw[c_EP]) begin
            w_bus = {4'h0, r_pc};
        end else if (!w_cw[c_NCE]) begin
            w_bus = w_mem;
        end else if (!w_cw[c_NEI]) begin
            w_bus = {4'h0, r_ir[3:0]};
        end else if (w_cw[c_EA]) begin
            w_bus = r_a;
        end else if (w_cw[c_EU]) begin
            w_bus = w_alu;
        end
    end

    // Fetch-side registers: program counter, memory address, instruction.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_pc  <= 4'h0;
            r_mar <= 4'h0;
            r_ir  <= 8'h00;
        end else begin
            if (w_cw[c_CP]) begin
                r_pc <= r_pc + 4'd1;
            end
            if (!w_cw[c_NLM]) begin
                r_mar <= w_bus[3:0];
            end
            if (!w_cw[c_NLI]) begin
                r_ir <= w_bus;
            end
        end
    end

    // Execute-side registers: accumulator, B and output register.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_a   <= 8'h00;
            r_b   <= 8'h00;
            r_out <= 8'h00;
        end else begin
            if (!w_cw[c_NLA]) begin
                r_a <= w_bus;
            end
            if (!w_cw[c_NLB]) begin
                r_b <= w_bus;
            end
            if (!w_cw[c_NLO]) begin
                r_out <= w_bus;
            end
        end
    end

    assign HLT      = w_hlt;
    assign LEDOUT   = r_out;
    assign CONTWORD = w_cw;

endmodule
`default_nettype wire

// File: tb/tb_sap1_computer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sap1_computer
//  Description : Bench for sap1_computer. Three instances (built-in program,
//                wrap-around subtract image, all-NOP image) share one clear.
//                An instruction-level model fills a scoreboard with the
//                expected per-cycle outputs; a negedge monitor pops and
//                compares. Clear is re-asserted at random points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sap1_computer;

    localparam int MAXC = 128;

    // Images written independently of the design package.
    localparam logic [127:0] IMG_BUILTIN = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h14, 8'h10, 8'h00,
        8'h00, 8'h00, 8'h00, 8'hF0, 8'hE0, 8'h2B, 8'h1A, 8'h09
    };
    // LDA F, SUB E, OUT, HLT; E=0x07, F=0x05 -> 0x05-0x07 = 0xFE
    localparam logic [127:0] IMG_SUB = {
        8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hE0, 8'h2E, 8'h0F
    };
    // Opcode 3 everywhere: executes as NOP, PC must wrap 15 -> 0.
    localparam logic [127:0] IMG_NOP = {16{8'h30}};

    typedef struct packed {
        logic [2:0][11:0] cw;
        logic [2:0][3:0]  pc;
        logic [2:0][7:0]  a;
        logic [2:0][7:0]  led;
        logic [2:0]       hlt;
    } entry_t;

    logic clk = 1'b0;
    logic Clr;
    logic mon_en;

    logic [2:0]       hlt_o;
    logic [2:0][7:0]  led_o;
    logic [2:0][11:0] cw_o;
    logic [2:0][3:0]  act_pc;
    logic [2:0][7:0]  act_a;

    int n_checks = 0;
    int n_fail   = 0;

    entry_t sbq[$];
    entry_t e_mon;

    // Model scratch: expected per-cycle values for each instance.
    logic [11:0] e_cw  [3][MAXC];
    logic [3:0]  e_pc  [3][MAXC];
    logic [7:0]  e_a   [3][MAXC];
    logic [7:0]  e_led [3][MAXC];
    logic        e_hlt [3][MAXC];
    int          m_c;
    int          m_n;
    logic [3:0]  m_pc;
    logic [7:0]  m_a;
    logic [7:0]  m_led;

    always #5 clk = ~clk;

    sap1_computer dut0 (
        .Clk(clk), .Clr(Clr), .HLT(hlt_o[0]), .LEDOUT(led_o[0]), .CONTWORD(cw_o[0])
    );
    sap1_computer #(.MEM_IMAGE(IMG_SUB)) dut1 (
        .Clk(clk), .Clr(Clr), .HLT(hlt_o[1]), .LEDOUT(led_o[1]), .CONTWORD(cw_o[1])
    );
    sap1_computer #(.MEM_IMAGE(IMG_NOP)) dut2 (
        .Clk(clk), .Clr(Clr), .HLT(hlt_o[2]), .LEDOUT(led_o[2]), .CONTWORD(cw_o[2])
    );

    assign act_pc = {dut2.r_pc, dut1.r_pc, dut0.r_pc};
    assign act_a  = {dut2.r_a,  dut1.r_a,  dut0.r_a};

    // Record one expected cycle for instance k from the model state.
    task automatic put(input int k, input logic [11:0] cw, input logic h);
        if (m_c < m_n) begin
            e_cw[k][m_c]  = cw;
            e_pc[k][m_c]  = m_pc;
            e_a[k][m_c]   = m_a;
            e_led[k][m_c] = m_led;
            e_hlt[k][m_c] = h;
        end
        m_c++;
    endtask

    // Instruction-level model: run image from address 0 for n cycles.
    task automatic model(input int k, input logic [127:0] img, input int n);
        logic [7:0] ins;
        logic [7:0] opnd;
        m_c = 0; m_n = n; m_pc = 4'h0; m_a = 8'h00; m_led = 8'h00;
        while (m_c < m_n) begin
            ins  = img[8*m_pc +: 8];
            opnd = img[8*ins[3:0] +: 8];
            put(k, 12'h5E3, 1'b0);
            put(k, 12'hBE3, 1'b0);
            m_pc = m_pc + 4'd1;
            put(k, 12'h263, 1'b0);
            case (ins[7:4])
                4'h0: begin
                    put(k, 12'h1A3, 1'b0); put(k, 12'h2C3, 1'b0);
                    m_a = opnd;
                    put(k, 12'h3E3, 1'b0);
                end
                4'h1: begin
                    put(k, 12'h1A3, 1'b0); put(k, 12'h2E1, 1'b0); put(k, 12'h3C7, 1'b0);
                    m_a = m_a + opnd;
                end
                4'h2: begin
                    put(k, 12'h1A3, 1'b0); put(k, 12'h2E1, 1'b0); put(k, 12'h3CF, 1'b0);
                    m_a = m_a - opnd;
                end
                4'hE: begin
                    put(k, 12'h3F2, 1'b0);
                    m_led = m_a;
                    put(k, 12'h3E3, 1'b0); put(k, 12'h3E3, 1'b0);
                end
                4'hF: begin
                    put(k, 12'h3E3, 1'b0);
                    while (m_c < m_n) put(k, 12'h3E3, 1'b1);
                end
                default: begin
                    put(k, 12'h3E3, 1'b0); put(k, 12'h3E3, 1'b0); put(k, 12'h3E3, 1'b0);
                end
            endcase
        end
    endtask

    // Fill the scoreboard with n cycles of expectations for all instances.
    task automatic build(input int n);
        entry_t e;
        sbq.delete();
        model(0, IMG_BUILTIN, n);
        model(1, IMG_SUB, n);
        model(2, IMG_NOP, n);
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 3; k++) begin
                e.cw[k]  = e_cw[k][c];
                e.pc[k]  = e_pc[k][c];
                e.a[k]   = e_a[k][c];
                e.led[k] = e_led[k][c];
                e.hlt[k] = e_hlt[k][c];
            end
            sbq.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got 0x%0h expected 0x%0h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: reset values while clear is high, scoreboard otherwise.
    always @(negedge clk) begin
        if (Clr) begin
            for (int k = 0; k < 3; k++) begin
                chk("rst_cw",  k, cw_o[k], 12'h5E3);
                chk("rst_pc",  k, {8'h0, act_pc[k]}, 12'h0);
                chk("rst_a",   k, {4'h0, act_a[k]}, 12'h0);
                chk("rst_led", k, {4'h0, led_o[k]}, 12'h0);
                chk("rst_hlt", k, {11'h0, hlt_o[k]}, 12'h0);
            end
        end else if (mon_en) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty at %0t: got no expectation, required one", $time);
            end else begin
                e_mon = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk("cw",  k, cw_o[k], e_mon.cw[k]);
                    chk("pc",  k, {8'h0, act_pc[k]}, {8'h0, e_mon.pc[k]});
                    chk("a",   k, {4'h0, act_a[k]}, {4'h0, e_mon.a[k]});
                    chk("led", k, {4'h0, led_o[k]}, {4'h0, e_mon.led[k]});
                    chk("hlt", k, {11'h0, hlt_o[k]}, {11'h0, e_mon.hlt[k]});
                end
            end
        end
    end

    // Release clear, run n cycles, then abort asynchronously mid-phase.
    task automatic run(input int n);
        build(n);
        @(posedge clk); #2;
        Clr = 1'b0;
        mon_en = 1'b1;
        repeat (n) @(negedge clk);
        @(posedge clk); #2;
        mon_en = 1'b0;
        Clr = 1'b1;
    endtask

    // Stimulus: full run, abort during SUB, rerun, random aborts, NOP wrap.
    initial begin
        Clr = 1'b1;
        mon_en = 1'b0;
        run(45);
        run(int'($urandom_range(17, 12)));
        run(30);
        repeat (6) run(int'($urandom_range(40, 1)));
        run(110);
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
